// File: rtl/ibuffer_warp_n.sv
// ibuffer_warp_n : per-warp instruction buffer between decode and issue.
//
// Holds DEPTH decoded instructions in a circular buffer. Three pointers:
//   WP - next write slot, RP - next instruction to issue for the first time,
//   HP - oldest live entry (an outstanding memory op awaiting feedback).
// Pointers are PW = log2(DEPTH)+1 bits wide so full and empty are distinct.
//
// Memory instructions stay live after issue (INFLIGHT) until the memory
// stage reports every lane served (PosFB clears lanes) or a miss (ZeroFB);
// unfinished ones go to REPLAY and re-issue with the remaining lane mask.
// Only one memory op may be outstanding at a time.
//
// Ports (grouped):
//   clk, rst (async, active-low)
//   IF   : Valid_IF_IB in, Req_IB_IF out (fetch permitted)
//   ID   : Valid/Payload/Src1/Src2/Dst/Src*_Valid/RegWrite/Mem/Exit _ID_IB
//   SIMT : DropInstr_SIMT_IB, ActiveMask_SIMT_IB
//   IU   : Req_IB_IU/Grt_IU_IB, Exit_Req_IB_IU/Exit_Grt_IU_IB
//   OC   : Stall_OC_IB in; Payload/ActiveMask/ScbID/Replay _IB_OC out
//   Scb  : Block/Empty/ScbID _Scb_IB in; RP-entry registers, RP_Grt,
//          Replayable, Replay_Complete(+ScbID) out
//   MEM  : PosFB_Valid_MEM_IB, PosFB_MEM_IB, ZeroFB_Valid_MEM_IB
//   Count_IB out (occupied entries, WP-HP)
//
// Optional feature: define IBUF_FLUSH_EN to add the Flush_IB input, which
// drops every not-yet-issued (WAIT) entry and rewinds WP to RP.
module ibuffer_warp_n #(
  parameter  int NUM_THREADS = 8,
  parameter  int DEPTH       = 4,
  parameter  int PAYLOAD_W   = 64,
  parameter  int SCB_ID_W    = 2,
  localparam int PW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // fetch
  input  logic                   Valid_IF_IB,
  output logic                   Req_IB_IF,
  // decode
  input  logic                   Valid_ID_IB,
  input  logic [PAYLOAD_W-1:0]   Payload_ID_IB,
  input  logic [4:0]             Src1_ID_IB,
  input  logic [4:0]             Src2_ID_IB,
  input  logic [4:0]             Dst_ID_IB,
  input  logic                   Src1_Valid_ID_IB,
  input  logic                   Src2_Valid_ID_IB,
  input  logic                   RegWrite_ID_IB,
  input  logic                   Mem_ID_IB,
  input  logic                   Exit_ID_IB,
  // SIMT stack
  input  logic                   DropInstr_SIMT_IB,
  input  logic [NUM_THREADS-1:0] ActiveMask_SIMT_IB,
  // issue unit
  output logic                   Req_IB_IU,
  input  logic                   Grt_IU_IB,
  output logic                   Exit_Req_IB_IU,
  input  logic                   Exit_Grt_IU_IB,
  // operand collector
  input  logic                   Stall_OC_IB,
  output logic [PAYLOAD_W-1:0]   Payload_IB_OC,
  output logic [NUM_THREADS-1:0] ActiveMask_IB_OC,
  output logic [SCB_ID_W-1:0]    ScbID_IB_OC,
  output logic                   Replay_IB_OC,
  // scoreboard
  input  logic                   Block_Scb_IB,
  input  logic                   Empty_Scb_IB,
  input  logic [SCB_ID_W-1:0]    ScbID_Scb_IB,
  output logic [4:0]             Src1_IB_Scb,
  output logic [4:0]             Src2_IB_Scb,
  output logic [4:0]             Dst_IB_Scb,
  output logic                   Src1_Valid_IB_Scb,
  output logic                   Src2_Valid_IB_Scb,
  output logic                   Dst_Valid_IB_Scb,
  output logic                   RP_Grt_IB_Scb,
  output logic                   Replayable_IB_Scb,
  output logic                   Replay_Complete_IB_Scb,
  output logic [SCB_ID_W-1:0]    Replay_Complete_ScbID_IB_Scb,
  // memory feedback
  input  logic                   PosFB_Valid_MEM_IB,
  input  logic [NUM_THREADS-1:0] PosFB_MEM_IB,
  input  logic                   ZeroFB_Valid_MEM_IB,
`ifdef IBUF_FLUSH_EN
  input  logic                   Flush_IB,
`endif
  output logic [PW-1:0]          Count_IB
);

  typedef enum logic [1:0] {S_INV, S_WAIT, S_INFL, S_RPL} st_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0]   pay;
    logic [4:0]             s1;
    logic [4:0]             s2;
    logic [4:0]             dst;
    logic                   v1;
    logic                   v2;
    logic                   rw;
    logic                   mem;
    logic                   ext;
    logic [NUM_THREADS-1:0] mask;
    logic [SCB_ID_W-1:0]    scb;
  } ent_t;

  st_e  [DEPTH-1:0] st_q, st_d;
  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d, hp_q, hp_d;
  logic             exited_q, exited_d;

  logic [PW-2:0]          hp_idx, rp_idx, wp_idx;
  st_e                    hp_st, rp_st;
  ent_t                   hp_e, rp_e;
  logic                   hp_busy, hp_infl, pos_hit, zero_hit, fb_done;
  logic [NUM_THREADS-1:0] fb_mask;
  logic                   replay_req, rp_wait, new_req, exit_req;
  logic                   rpl_gnt, new_gnt, exit_gnt, wr_en;

  assign hp_idx = hp_q[PW-2:0];
  assign rp_idx = rp_q[PW-2:0];
  assign wp_idx = wp_q[PW-2:0];
  assign hp_st  = st_q[hp_idx];
  assign rp_st  = st_q[rp_idx];
  assign hp_e   = ent_q[hp_idx];
  assign rp_e   = ent_q[rp_idx];

  assign Count_IB = wp_q - hp_q;

  // Budget counts the fetch and decode already in flight toward us.
  assign Req_IB_IF = !exited_q &&
                     (({1'b0, Count_IB} + {{PW{1'b0}}, Valid_IF_IB} +
                       {{PW{1'b0}}, Valid_ID_IB}) < (PW+1)'(DEPTH));

  // A live memory op can only sit at HP, behind RP.
  assign hp_busy  = (hp_q != rp_q) && (hp_st == S_INFL || hp_st == S_RPL);
  assign hp_infl  = (hp_q != rp_q) && (hp_st == S_INFL);
  assign pos_hit  = hp_infl && PosFB_Valid_MEM_IB;
  assign zero_hit = hp_infl && ZeroFB_Valid_MEM_IB;
  assign fb_mask  = pos_hit ? (hp_e.mask & ~PosFB_MEM_IB) : hp_e.mask;
  assign fb_done  = pos_hit && (fb_mask == '0);

  // Feedback arriving this cycle can request the replay immediately.
  assign replay_req = ((hp_q != rp_q) && hp_st == S_RPL) ||
                      (hp_infl && !fb_done && (zero_hit || pos_hit));

  assign rp_wait  = (rp_q != wp_q) && (rp_st == S_WAIT);
  assign new_req  = rp_wait && !rp_e.ext && !Block_Scb_IB && !Stall_OC_IB &&
                    !replay_req && !(hp_busy && rp_e.mem);
  assign exit_req = rp_wait && rp_e.ext && Empty_Scb_IB && (hp_q == rp_q);

  assign rpl_gnt  = replay_req && !Stall_OC_IB && Grt_IU_IB;
  assign new_gnt  = new_req && Grt_IU_IB;
  assign exit_gnt = exit_req && Exit_Grt_IU_IB;

`ifdef IBUF_FLUSH_EN
  assign wr_en = Valid_ID_IB && !DropInstr_SIMT_IB && !Flush_IB;
`else
  assign wr_en = Valid_ID_IB && !DropInstr_SIMT_IB;
`endif

  assign Req_IB_IU      = (replay_req && !Stall_OC_IB) || new_req;
  assign Exit_Req_IB_IU = exit_req;

  // OC side: HP entry on replay, RP entry otherwise. A fresh issue carries
  // the ID the scoreboard is allocating right now.
  assign Payload_IB_OC    = replay_req ? hp_e.pay : rp_e.pay;
  assign ActiveMask_IB_OC = replay_req ? fb_mask  : rp_e.mask;
  assign ScbID_IB_OC      = replay_req ? hp_e.scb : ScbID_Scb_IB;
  assign Replay_IB_OC     = replay_req;

  assign Src1_IB_Scb                  = rp_e.s1;
  assign Src2_IB_Scb                  = rp_e.s2;
  assign Dst_IB_Scb                   = rp_e.dst;
  assign Src1_Valid_IB_Scb            = rp_e.v1;
  assign Src2_Valid_IB_Scb            = rp_e.v2;
  assign Dst_Valid_IB_Scb             = rp_e.rw;
  assign Replayable_IB_Scb            = rp_e.mem;
  assign RP_Grt_IB_Scb                = new_gnt;
  assign Replay_Complete_IB_Scb       = fb_done;
  assign Replay_Complete_ScbID_IB_Scb = hp_e.scb;

  always_comb begin
    st_d     = st_q;
    ent_d    = ent_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    hp_d     = hp_q;
    exited_d = exited_q;

`ifdef IBUF_FLUSH_EN
    if (Flush_IB)
      for (int i = 0; i < DEPTH; i++)
        if (st_q[i] == S_WAIT) st_d[i] = S_INV;
`endif

    // grant overrides flush for the entry being issued this cycle
    if (new_gnt) begin
      st_d[rp_idx] = rp_e.mem ? S_INFL : S_INV;
      if (rp_e.mem) ent_d[rp_idx].scb = ScbID_Scb_IB;
      rp_d = rp_q + 1'b1;
    end
    if (exit_gnt) begin
      st_d[rp_idx] = S_INV;
      rp_d         = rp_q + 1'b1;
      exited_d     = 1'b1;
    end

    if (pos_hit) begin
      ent_d[hp_idx].mask = fb_mask;
      st_d[hp_idx]       = fb_done ? S_INV : S_RPL;
    end else if (zero_hit) begin
      st_d[hp_idx] = S_RPL;
    end
    if (rpl_gnt) st_d[hp_idx] = S_INFL;

    if (wr_en) begin
      st_d[wp_idx]      = S_WAIT;
      ent_d[wp_idx].pay = Payload_ID_IB;
      ent_d[wp_idx].s1  = Src1_ID_IB;
      ent_d[wp_idx].s2  = Src2_ID_IB;
      ent_d[wp_idx].dst = Dst_ID_IB;
      ent_d[wp_idx].v1  = Src1_Valid_ID_IB;
      ent_d[wp_idx].v2  = Src2_Valid_ID_IB;
      ent_d[wp_idx].rw  = RegWrite_ID_IB;
      ent_d[wp_idx].mem = Mem_ID_IB;
      ent_d[wp_idx].ext = Exit_ID_IB;
      ent_d[wp_idx].mask = ActiveMask_SIMT_IB;
      wp_d = wp_q + 1'b1;
    end

`ifdef IBUF_FLUSH_EN
    if (Flush_IB) wp_d = rp_d;
`endif

    // Everything from HP up to RP is dead once HP's entry is dead, so HP
    // catches up with RP in one step. An empty buffer (HP==WP) just follows.
    if (st_d[hp_idx] == S_INV || hp_q == wp_q) hp_d = rp_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      hp_q     <= '0;
      exited_q <= 1'b0;
      ent_q    <= '0;
      for (int i = 0; i < DEPTH; i++) st_q[i] <= S_INV;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      hp_q     <= hp_d;
      exited_q <= exited_d;
      ent_q    <= ent_d;
      st_q     <= st_d;
    end
  end

`ifndef SYNTHESIS
  // decode must never write into a full buffer
  always_ff @(posedge clk)
    if (rst && wr_en) assert (Count_IB != PW'(DEPTH));
`endif

endmodule
